// File: rtl/seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl : N-digit multiplexed 7-segment scanner with PWM dimming
//                  and frame-synchronous double-buffered display data.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 12500,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [BRIGHT_W-1:0]     i_brightness,
  input  logic                    i_load,
  output logic                    o_pending,
  output logic                    o_frame_sync,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp
);

  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SUB_RAW = PRESCALE >> BRIGHT_W;
  localparam int SUB     = (SUB_RAW > 0) ? SUB_RAW : 1;
  localparam int SUB_W   = (SUB > 1) ? $clog2(SUB) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        pre_q,   pre_d;
  logic [SUB_W-1:0]        sub_q,   sub_d;
  logic [BRIGHT_W-1:0]     phase_q, phase_d;
  logic [DIG_W-1:0]        dig_q,   dig_d;

  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   stg_en_q,  stg_en_d,  act_en_q,  act_en_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q,  stg_dp_d,  act_dp_q,  act_dp_d;
  logic                    pending_q, pending_d;

  logic                    sync_q, sync_d;
  logic [NUM_DIGITS-1:0]   an_q,  an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q,  dp_d;

  logic                    pre_last;
  logic                    boundary;
  logic                    lit;
  logic [3:0]              cur_val;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0:    hex_decode = 7'b0000001;
      4'h1:    hex_decode = 7'b1001111;
      4'h2:    hex_decode = 7'b0010010;
      4'h3:    hex_decode = 7'b0000110;
      4'h4:    hex_decode = 7'b1001100;
      4'h5:    hex_decode = 7'b0100100;
      4'h6:    hex_decode = 7'b0100000;
      4'h7:    hex_decode = 7'b0001111;
      4'h8:    hex_decode = 7'b0000000;
      4'h9:    hex_decode = 7'b0000100;
      4'hA:    hex_decode = 7'b0001000;
      4'hB:    hex_decode = 7'b1100000;
      4'hC:    hex_decode = 7'b0110001;
      4'hD:    hex_decode = 7'b1000010;
      4'hE:    hex_decode = 7'b0110000;
      default: hex_decode = 7'b0111000;
    endcase
  endfunction

  assign pre_last = (pre_q == PRE_LAST);
  assign boundary = pre_last && (dig_q == DIG_LAST);

  // Scan counters: sub divides the slot into 2**BRIGHT_W PWM phases.
  always_comb begin
    pre_d   = pre_q + 1'b1;
    sub_d   = sub_q + 1'b1;
    phase_d = phase_q;
    dig_d   = dig_q;
    if (pre_last) begin
      pre_d   = '0;
      sub_d   = '0;
      phase_d = '0;
      dig_d   = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else if (sub_q == SUB_LAST) begin
      sub_d   = '0;
      phase_d = phase_q + 1'b1;
    end
  end

  // Staging captures every load; active only swaps at the frame boundary,
  // so a load coinciding with the boundary is held over to the next frame.
  always_comb begin
    stg_val_d = stg_val_q;
    stg_en_d  = stg_en_q;
    stg_dp_d  = stg_dp_q;
    act_val_d = act_val_q;
    act_en_d  = act_en_q;
    act_dp_d  = act_dp_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      act_val_d = stg_val_q;
      act_en_d  = stg_en_q;
      act_dp_d  = stg_dp_q;
      pending_d = 1'b0;
    end
    if (i_load) begin
      stg_val_d = i_value;
      stg_en_d  = i_digit_en;
      stg_dp_d  = i_dp;
      pending_d = 1'b1;
    end
  end

  assign cur_val = act_val_q[{dig_q, 2'b00} +: 4];
  assign lit     = act_en_q[dig_q] && (phase_q < i_brightness);

  always_comb begin
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    sync_d = boundary;
    if (lit) begin
      an_d[dig_q] = 1'b0;
      seg_d       = hex_decode(cur_val);
      dp_d        = ~act_dp_q[dig_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      sub_q     <= '0;
      phase_q   <= '0;
      dig_q     <= '0;
      stg_val_q <= '0;
      stg_en_q  <= '0;
      stg_dp_q  <= '0;
      act_val_q <= '0;
      act_en_q  <= '0;
      act_dp_q  <= '0;
      pending_q <= 1'b0;
      sync_q    <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      sub_q     <= sub_d;
      phase_q   <= phase_d;
      dig_q     <= dig_d;
      stg_val_q <= stg_val_d;
      stg_en_q  <= stg_en_d;
      stg_dp_q  <= stg_dp_d;
      act_val_q <= act_val_d;
      act_en_q  <= act_en_d;
      act_dp_q  <= act_dp_d;
      pending_q <= pending_d;
      sync_q    <= sync_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign o_pending    = pending_q;
  assign o_frame_sync = sync_q;
  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_ctrl : table-driven bench for seg7_scan_ctrl (4 digits, 16/slot)
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int P  = 16;
  localparam int BW = 2;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      en;
    logic [3:0]      dp;
    logic [1:0]      bright;
    logic [3:0][6:0] seg;   // expected pattern per digit
    logic [3:0][4:0] lit;   // expected lit cycles per digit per frame
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   i_value;
  logic [3:0]    i_digit_en;
  logic [3:0]    i_dp;
  logic [1:0]    i_brightness;
  logic          i_load;
  logic          o_pending;
  logic          o_frame_sync;
  logic [3:0]    o_an;
  logic [6:0]    o_seg;
  logic          o_dp;

  int checks   = 0;
  int failures = 0;
  vec_t tbl [7];

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BRIGHT_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_value      (i_value),
    .i_digit_en   (i_digit_en),
    .i_dp         (i_dp),
    .i_brightness (i_brightness),
    .i_load       (i_load),
    .o_pending    (o_pending),
    .o_frame_sync (o_frame_sync),
    .o_an         (o_an),
    .o_seg        (o_seg),
    .o_dp         (o_dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d,
                              input logic [1:0] b, input logic [27:0] s, input logic [19:0] l);
    vec_t r;
    r.value = v; r.en = e; r.dp = d; r.bright = b; r.seg = s; r.lit = l;
    return r;
  endfunction

  task automatic set_inputs(input vec_t v);
    i_value      = v.value;
    i_digit_en   = v.en;
    i_dp         = v.dp;
    i_brightness = v.bright;
  endtask

  task automatic do_load(input vec_t v, input string tag);
    set_inputs(v);
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    chk({tag, "_pending_set"}, 32'(o_pending), 32'd1);
  endtask

  // Bounded wait for o_frame_sync; reports lit cycles seen on the way.
  task automatic wait_sync(input string tag, output int lit_cycles);
    bit found = 0;
    lit_cycles = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (o_an != 4'hF) lit_cycles++;
      if (o_frame_sync === 1'b1) found = 1;
    end
    chk({tag, "_sync_seen"}, 32'(found), 32'd1);
  endtask

  // Called on the negedge of a sync cycle; samples exactly one frame and
  // finishes on the negedge of the next sync cycle.
  task automatic observe_frame(input vec_t v, input string tag);
    int lit_cnt [4];
    int bad   = 0;
    int syncs = 0;
    int d;
    for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (o_frame_sync === 1'b1) syncs++;
      if (o_an === 4'hF) begin
        if (o_seg !== 7'h7F || o_dp !== 1'b1) bad++;
      end else if ($countones(~o_an) != 1) begin
        bad++;
      end else begin
        d = 0;
        for (int k = 0; k < 4; k++) if (o_an[k] == 1'b0) d = k;
        lit_cnt[d]++;
        if (o_seg !== v.seg[d] || o_dp !== ~v.dp[d]) bad++;
      end
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_lit_d%0d", tag, k), 32'(lit_cnt[k]), 32'(v.lit[k]));
    chk({tag, "_pattern_errs"}, 32'(bad), 32'd0);
    chk({tag, "_syncs_per_frame"}, 32'(syncs), 32'd1);
  endtask

  task automatic check_blank(input int cycles, input string tag);
    int bad = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (o_an !== 4'hF || o_seg !== 7'h7F || o_dp !== 1'b1 || o_pending !== 1'b0) bad++;
    end
    chk({tag, "_blank_errs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int lit_seen;
    vec_t va, vb;

    tbl[0] = mk(16'h3210, 4'hF,    4'b0100, 2'd3, {7'h06, 7'h12, 7'h4F, 7'h01}, {5'd12, 5'd12, 5'd12, 5'd12});
    tbl[1] = mk(16'h3210, 4'hF,    4'b0100, 2'd0, {7'h06, 7'h12, 7'h4F, 7'h01}, {5'd0,  5'd0,  5'd0,  5'd0});
    tbl[2] = mk(16'h3210, 4'hF,    4'b0100, 2'd1, {7'h06, 7'h12, 7'h4F, 7'h01}, {5'd4,  5'd4,  5'd4,  5'd4});
    tbl[3] = mk(16'h3210, 4'b1010, 4'b0100, 2'd3, {7'h06, 7'h12, 7'h4F, 7'h01}, {5'd12, 5'd0,  5'd12, 5'd0});
    tbl[4] = mk(16'hFEDC, 4'hF,    4'b1001, 2'd2, {7'h38, 7'h30, 7'h42, 7'h31}, {5'd8,  5'd8,  5'd8,  5'd8});
    tbl[5] = mk(16'hBA98, 4'hF,    4'b0000, 2'd3, {7'h60, 7'h08, 7'h04, 7'h00}, {5'd12, 5'd12, 5'd12, 5'd12});
    tbl[6] = mk(16'h7654, 4'hF,    4'b1111, 2'd3, {7'h0F, 7'h20, 7'h24, 7'h4C}, {5'd12, 5'd12, 5'd12, 5'd12});

    rst = 1'b1; i_load = 1'b0; i_value = '0; i_digit_en = '0; i_dp = '0; i_brightness = '0;
    repeat (3) @(negedge clk);
    chk("rst_an",   32'(o_an),         32'hF);
    chk("rst_seg",  32'(o_seg),        32'h7F);
    chk("rst_dp",   32'(o_dp),         32'd1);
    chk("rst_pend", 32'(o_pending),    32'd0);
    chk("rst_sync", 32'(o_frame_sync), 32'd0);
    rst = 1'b0;
    i_brightness = 2'd3;
    check_blank(200, "idle");

    for (int i = 0; i < 7; i++) begin
      do_load(tbl[i], $sformatf("v%0d", i));
      wait_sync($sformatf("v%0d", i), lit_seen);
      if (i == 0) chk("v0_blank_before_apply", 32'(lit_seen), 32'd0);
      chk($sformatf("v%0d_pending_clear", i), 32'(o_pending), 32'd0);
      observe_frame(tbl[i], $sformatf("v%0d", i));
    end

    // Load A mid-frame, then load B exactly on the boundary cycle.
    va = tbl[0];
    vb = tbl[4];
    repeat (10) @(negedge clk);
    do_load(va, "bnd_a");
    repeat (52) @(negedge clk);
    set_inputs(vb);
    i_brightness = va.bright;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    chk("bnd_sync_after_boundary", 32'(o_frame_sync), 32'd1);
    chk("bnd_pending_held",        32'(o_pending),    32'd1);
    observe_frame(va, "bnd_a");
    chk("bnd_pending_clear_b", 32'(o_pending), 32'd0);
    i_brightness = vb.bright;
    observe_frame(vb, "bnd_b");

    // Reset while digit 1 is lit with staged data outstanding.
    i_brightness = 2'd3;
    repeat (5) @(negedge clk);
    do_load(tbl[5], "mid");
    repeat (14) @(negedge clk);
    chk("mid_digit1_lit", 32'(o_an), 32'hD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_an",   32'(o_an),      32'hF);
    chk("mid_rst_pend", 32'(o_pending), 32'd0);
    chk("mid_rst_seg",  32'(o_seg),     32'h7F);
    chk("mid_rst_dp",   32'(o_dp),      32'd1);
    check_blank(200, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
